// File: rtl/ntsc_line_prefetch.sv
// Double-banked line prefetcher that feeds pixels to the interlaced NTSC timing generator.
// While one line is on screen, line pixel_y+2 of the same field is fetched into the other bank.
module ntsc_line_prefetch #(
  parameter int H_RES          = 560,
  parameter int V_RES          = 400,
  parameter int WORDS_PER_LINE = 140,
  parameter int ADDR_W         = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              v_sync,
  input  logic              pixel_is_visible,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [3:0]        pixel_data,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              fetch_busy,
  output logic              underrun_err,
  input  logic              err_clr
);

  localparam int         WI_W  = $clog2(WORDS_PER_LINE);
  localparam logic [3:0] BLANK = 4'b0001;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       bank0 [WORDS_PER_LINE];
  logic [15:0]       bank1 [WORDS_PER_LINE];
  logic [9:0]        tag0, tag1;
  logic [1:0]        valid;
  logic              parity, vis_q;
  logic [WI_W-1:0]   word_idx;
  logic [9:0]        tgt_line, pend_line;
  logic              tgt_bank, pend_bank, pend;
  logic [ADDR_W-1:0] pend_addr;

  logic              hit0, hit1, has_hit, line_start, ls_fetch, ev, ev_bank;
  logic              in_range, last_word, go_new, go_pend, hold_ev, err_set;
  logic [10:0]       ls_line;
  logic [9:0]        ev_line;
  logic [ADDR_W-1:0] ev_addr;
  logic [15:0]       rd_word;

  // Bank 0 wins if both tags match; the fetch target is always the bank not on screen.
  assign hit0       = valid[0] && (tag0 == pixel_y);
  assign hit1       = valid[1] && (tag1 == pixel_y) && !hit0;
  assign has_hit    = hit0 || hit1;
  assign line_start = pixel_is_visible && !vis_q;
  assign ls_line    = {1'b0, pixel_y} + 11'd2;
  assign ls_fetch   = line_start && !v_sync && (ls_line < 11'(V_RES));
  assign ev         = v_sync || ls_fetch;
  assign ev_line    = v_sync ? {9'd0, ~parity} : ls_line[9:0];
  assign ev_bank    = v_sync ? 1'b0 : hit0;
  assign ev_addr    = base_addr + ADDR_W'(ev_line) * ADDR_W'(WORDS_PER_LINE);

  // An event with a handshake outstanding is parked until that ack, so mem_req never drops early.
  assign last_word  = (word_idx == WI_W'(WORDS_PER_LINE - 1));
  assign go_new     = ev && (state != REQ || mem_ack);
  assign go_pend    = pend && !ev && (state == REQ) && mem_ack;
  assign hold_ev    = ev && (state == REQ) && !mem_ack;
  assign err_set    = (pixel_is_visible && !has_hit) || (ev && state != IDLE);

  assign in_range   = (pixel_x < 10'(H_RES));
  assign rd_word    = hit1 ? bank1[pixel_x[9:2]] : bank0[pixel_x[9:2]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    fetch_busy = 1'b1;
    case (state)
      IDLE: begin
        fetch_busy = 1'b0;
        if (ev) state_nxt = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack && last_word && !ev && !pend) state_nxt = DONE;
      end
      DONE:    state_nxt = ev ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_data   <= BLANK;
      mem_addr     <= '0;
      underrun_err <= 1'b0;
      valid        <= '0;
      tag0         <= '0;
      tag1         <= '0;
      parity       <= 1'b0;
      vis_q        <= 1'b0;
      word_idx     <= '0;
      tgt_line     <= '0;
      tgt_bank     <= 1'b0;
      pend         <= 1'b0;
      pend_line    <= '0;
      pend_bank    <= 1'b0;
      pend_addr    <= '0;
    end else begin
      vis_q <= pixel_is_visible;

      if (pixel_is_visible && has_hit && in_range) pixel_data <= rd_word[{pixel_x[1:0], 2'b00} +: 4];
      else                                         pixel_data <= BLANK;

      if (err_set)      underrun_err <= 1'b1;
      else if (err_clr) underrun_err <= 1'b0;

      if (v_sync)                                 parity <= ~parity;
      else if (line_start && pixel_y[0] != parity) parity <= pixel_y[0];

      if (state == DONE && !ev) begin
        valid[tgt_bank] <= 1'b1;
        if (tgt_bank) tag1 <= tgt_line;
        else          tag0 <= tgt_line;
      end
      if (ev)     valid[ev_bank] <= 1'b0;
      if (v_sync) valid          <= '0;

      if (go_new) begin
        word_idx <= '0;
        mem_addr <= ev_addr;
        tgt_line <= ev_line;
        tgt_bank <= ev_bank;
        pend     <= 1'b0;
      end else if (go_pend) begin
        word_idx <= '0;
        mem_addr <= pend_addr;
        tgt_line <= pend_line;
        tgt_bank <= pend_bank;
        pend     <= 1'b0;
      end else if (state == REQ && mem_ack) begin
        word_idx <= word_idx + WI_W'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
      end

      if (hold_ev) begin
        pend      <= 1'b1;
        pend_line <= ev_line;
        pend_bank <= ev_bank;
        pend_addr <= ev_addr;
      end
    end
  end

  // NOTE: line banks carry no reset; the valid bits alone decide whether their contents are used.
  always_ff @(posedge clk) begin
    if (state == REQ && mem_ack) begin
      if (tgt_bank) bank1[word_idx] <= mem_rdata;
      else          bank0[word_idx] <= mem_rdata;
    end
  end

endmodule
